ahb_bram_ctrl: RTL and testbench

- AHB-Lite slave that acts as initiator toward the single-port byte-write BRAM: drives ram_we/ram_addr/ram_din and returns ram_dout.
- Sits between the Cortex-M0 bus matrix and the code/data BRAM.
- BRAM reads are read-first with 1-cycle latency.
- Zero-wait reads and writes, except one wait state for a read immediately following a write (port conflict).

---
 rtl/ahb_bram_ctrl.sv | 136 +++++++++++++
 tb/tb_ahb_bram_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave driving a single-port, byte-write, read-first BRAM (1-cycle read latency).
// Define AHB_BRAM_ERR_EN to return ERROR for oversized or misaligned transfers.
module ahb_bram_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int COL_WIDTH  = 8,
    parameter int NB_COL     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        HSEL,
    input  logic [31:0]                 HADDR,
    input  logic [1:0]                  HTRANS,
    input  logic                        HWRITE,
    input  logic [2:0]                  HSIZE,
    input  logic [NB_COL*COL_WIDTH-1:0] HWDATA,
    input  logic                        HREADY,
    output logic                        HREADYOUT,
    output logic                        HRESP,
    output logic [NB_COL*COL_WIDTH-1:0] HRDATA,
    output logic [NB_COL-1:0]           ram_we,
    output logic [ADDR_WIDTH-1:0]       ram_addr,
    output logic [NB_COL*COL_WIDTH-1:0] ram_din,
    input  logic [NB_COL*COL_WIDTH-1:0] ram_dout
);

`ifdef AHB_BRAM_ERR_EN
    typedef enum logic [2:0] {ST_IDLE, ST_WDATA, ST_RSTALL, ST_RDATA, ST_ERR1, ST_ERR2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_WDATA, ST_RSTALL, ST_RDATA} state_t;
`endif

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [NB_COL-1:0]       mask_q, mask_d;

    logic                    accept;
    logic [ADDR_WIDTH-1:0]   wordAddr;
    logic [NB_COL-1:0]       laneMask;
    logic                    unused_ok;

    assign accept    = HSEL & HTRANS[1] & HREADY;
    assign wordAddr  = HADDR[ADDR_WIDTH+1:2];
    assign HRDATA    = ram_dout;
    assign ram_din   = HWDATA;
    assign unused_ok = ^{HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

    // Low address bits beyond the transfer size are ignored; sizes above word act as word.
    always_comb begin
        laneMask = 4'b1111;
        case (HSIZE)
            3'd0:    laneMask = 4'b0001 << HADDR[1:0];
            3'd1:    laneMask = HADDR[1] ? 4'b1100 : 4'b0011;
            default: laneMask = 4'b1111;
        endcase
    end

`ifdef AHB_BRAM_ERR_EN
    logic sizeErr;
    assign sizeErr = (HSIZE > 3'd2) ||
                     ((HSIZE == 3'd1) && HADDR[0]) ||
                     ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        mask_d    = mask_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        ram_we    = '0;
        ram_addr  = wordAddr;

        // A write owns the port only in its data phase; a read normally uses it in its address phase.
        case (state_q)
            ST_WDATA: begin
                ram_addr = addr_q;
                ram_we   = mask_q;
            end
            ST_RSTALL: begin
                ram_addr  = addr_q;
                HREADYOUT = 1'b0;
            end
`ifdef AHB_BRAM_ERR_EN
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: begin
                HRESP = 1'b1;
            end
`endif
            default: ;
        endcase

        case (state_q)
            ST_RSTALL: state_d = ST_RDATA;
`ifdef AHB_BRAM_ERR_EN
            ST_ERR1:   state_d = ST_ERR2;
`endif
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
`ifdef AHB_BRAM_ERR_EN
                    if (sizeErr) begin
                        state_d = ST_ERR1;
                    end else
`endif
                    if (HWRITE) begin
                        state_d = ST_WDATA;
                        addr_d  = wordAddr;
                        mask_d  = laneMask;
                    end else if (state_q == ST_WDATA) begin
                        // Port is busy with the write this cycle, so replay the read address next cycle.
                        state_d = ST_RSTALL;
                        addr_d  = wordAddr;
                    end else begin
                        state_d = ST_RDATA;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Bench for ahb_bram_ctrl: directed plus random AHB traffic checked against a word-array memory model.
// Honours AHB_BRAM_ERR_EN when the design is built with it.
module tb_ahb_bram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [3:0]  ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    typedef struct {
        logic        valid;
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [3:0]  mask;
        logic [31:0] expData;
        int          expWaits;
        int          waits;
    } xfer_t;

    xfer_t       dirQ[$];
    int          randLeft = 0;
    int          numChecks = 0;
    int          numFails = 0;
    logic        preload;
    logic [31:0] initMem [0:4095];
    logic [31:0] refMem  [0:4095];
    logic [31:0] bramMem [0:4095];

    ahb_bram_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;
    assign HREADY = HREADYOUT;

    // Read-first byte-write BRAM seen by the DUT.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++) bramMem[i] <= initMem[i];
        end else begin
            ram_dout <= bramMem[ram_addr];
            for (int i = 0; i < 4; i++)
                if (ram_we[i]) bramMem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic xfer_t makeXfer(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        xfer_t x;
        x.valid = 1'b1;  x.sel = 1'b1;  x.trans = 2'b10;
        x.write = w;     x.addr = a;    x.size = s;     x.wdata = d;
        x.err = 1'b0;    x.mask = 4'b0; x.expData = 32'h0;
        x.expWaits = 0;  x.waits = 0;
        return x;
    endfunction

    function automatic xfer_t idleXfer();
        xfer_t x;
        x = makeXfer(1'b0, 32'h0, 3'd0, 32'h0);
        x.valid = 1'b0;
        return x;
    endfunction

    // Lanes touched: the addressed byte, the addressed halfword, or the whole word.
    function automatic logic [3:0] refLanes(input logic [31:0] a, input logic [2:0] s);
        logic [3:0] m;
        int first, count;
        m = 4'b0;
        if (s == 3'd0)      begin first = int'(a[1:0]);     count = 1; end
        else if (s == 3'd1) begin first = 2 * int'(a[1]);   count = 2; end
        else                begin first = 0;                count = 4; end
        for (int i = 0; i < count; i++) m[first + i] = 1'b1;
        return m;
    endfunction

    function automatic logic refErr(input logic [31:0] a, input logic [2:0] s);
`ifdef AHB_BRAM_ERR_EN
        return (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00);
`else
        return (a[0] & 1'b0) | (s[0] & 1'b0);
`endif
    endfunction

    function automatic xfer_t modelAccept(input xfer_t x, input xfer_t prev);
        int w;
        w = int'(x.addr[13:2]);
        x.err   = refErr(x.addr, x.size);
        x.mask  = refLanes(x.addr, x.size);
        x.waits = 0;
        if (x.err) x.expWaits = 1;
        else if (!x.write && prev.valid && prev.write && !prev.err) x.expWaits = 1;
        else x.expWaits = 0;
        if (x.write && !x.err)
            for (int i = 0; i < 4; i++)
                if (x.mask[i]) refMem[w][8*i +: 8] = x.wdata[8*i +: 8];
        x.expData = refMem[w];
        return x;
    endfunction

    function automatic xfer_t nextXfer();
        xfer_t x;
        logic [31:0] a;
        logic [2:0] s;
        int r;
        if (dirQ.size() > 0) return dirQ.pop_front();
        if (randLeft == 0) return idleXfer();
        randLeft--;
        a = $urandom();
        a[13:2] = 12'($urandom_range(0, 15));
        r = $urandom_range(0, 9);
        if (r < 3)      s = 3'd0;
        else if (r < 6) s = 3'd1;
        else if (r < 9) s = 3'd2;
        else            s = 3'($urandom_range(3, 7));
        x = makeXfer(1'($urandom_range(0, 1)), a, s, $urandom());
        r = $urandom_range(0, 9);
        if (r == 0)      x.sel = 1'b0;
        else if (r == 1) x.trans = 2'($urandom_range(0, 1));
        else             x.trans = 2'($urandom_range(2, 3));
        return x;
    endfunction

    task automatic applyStimulus(input xfer_t ap, input xfer_t dp);
        if (ap.valid) begin
            HSEL = ap.sel;  HTRANS = ap.trans;  HADDR = ap.addr;
            HWRITE = ap.write;  HSIZE = ap.size;
        end else begin
            HSEL = 1'b0;  HTRANS = 2'b00;  HADDR = $urandom();
            HWRITE = 1'($urandom_range(0, 1));  HSIZE = 3'd2;
        end
        HWDATA = (dp.valid && dp.write) ? dp.wdata : $urandom();
    endtask

    // Pipelined master: one address phase and one data phase in flight, called at a falling edge.
    task automatic runTraffic();
        xfer_t ap, dp;
        logic rdy;
        logic [3:0] expWe;
        int cycles;
        cycles = 0;
        ap = nextXfer();
        dp = idleXfer();
        while ((ap.valid || dp.valid) && cycles < 20000) begin
            applyStimulus(ap, dp);
            #1;
            expWe = (dp.valid && dp.write && !dp.err) ? dp.mask : 4'b0;
            checkOutput("ram_we", 32'(ram_we), 32'(expWe));
            if (expWe != 4'b0) checkOutput("ram_addr", 32'(ram_addr), 32'(dp.addr[13:2]));
            if (dp.valid) begin
                if (!HREADYOUT) begin
                    dp.waits++;
                    if (dp.waits > 3) begin
                        checkOutput("wait_bound", 32'(dp.waits), 32'(dp.expWaits));
                        break;
                    end
                end else begin
                    checkOutput("waits", 32'(dp.waits), 32'(dp.expWaits));
                    checkOutput("hresp", 32'(HRESP), 32'(dp.err));
                    if (!dp.write && !dp.err) checkOutput("hrdata", HRDATA, dp.expData);
                end
            end else begin
                checkOutput("idle_ready", 32'(HREADYOUT), 32'h1);
            end
            rdy = HREADYOUT;
            @(negedge clk);
            cycles++;
            if (rdy) begin
                if (ap.valid && ap.sel && ap.trans[1]) dp = modelAccept(ap, dp);
                else dp = idleXfer();
                ap = nextXfer();
            end
        end
        if (cycles >= 20000) checkOutput("cycle_bound", 32'(cycles), 32'h0);
    endtask

    task automatic resetMidStall();
        HSEL = 1'b1;  HTRANS = 2'b10;  HWRITE = 1'b1;  HSIZE = 3'd2;  HADDR = 32'h40;
        HWDATA = $urandom();
        @(negedge clk);
        HWDATA = 32'h5A5AC3C3;  HWRITE = 1'b0;
        #1;
        checkOutput("rst_wr_we", 32'(ram_we), 32'hF);
        @(negedge clk);
        HSEL = 1'b0;  HTRANS = 2'b00;
        #1;
        checkOutput("rst_stall_ready", 32'(HREADYOUT), 32'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_ready", 32'(HREADYOUT), 32'h1);
        checkOutput("rst_async_hresp", 32'(HRESP), 32'h0);
        checkOutput("rst_async_we", 32'(ram_we), 32'h0);
        refMem[16] = 32'h5A5AC3C3;
        @(negedge clk);
        rst_n = 1'b1;
        dirQ.push_back(makeXfer(1'b0, 32'h40, 3'd2, 32'h0));
        runTraffic();
    endtask

    initial begin
        rst_n = 1'b0;  preload = 1'b1;
        HSEL = 1'b0;  HTRANS = 2'b00;  HADDR = 32'h0;  HWRITE = 1'b0;  HSIZE = 3'd0;  HWDATA = 32'h0;
        for (int i = 0; i < 4096; i++) initMem[i] = $urandom();
        initMem[1] = 32'hCAFEBABE;
        for (int i = 0; i < 4096; i++) refMem[i] = initMem[i];

        @(negedge clk);
        checkOutput("reset_ready", 32'(HREADYOUT), 32'h1);
        checkOutput("reset_hresp", 32'(HRESP), 32'h0);
        checkOutput("reset_we", 32'(ram_we), 32'h0);
        repeat (2) @(negedge clk);
        preload = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        dirQ.push_back(makeXfer(1'b0, 32'h0000_0004, 3'd2, 32'h0));
        dirQ.push_back(makeXfer(1'b1, 32'h0000_0006, 3'd0, 32'h00AB0000));
        dirQ.push_back(makeXfer(1'b0, 32'h0000_0004, 3'd2, 32'h0));
        dirQ.push_back(makeXfer(1'b1, 32'h0000_0010, 3'd2, 32'h12345678));
        dirQ.push_back(makeXfer(1'b0, 32'h0000_0010, 3'd2, 32'h0));
        dirQ.push_back(makeXfer(1'b1, 32'h0000_0020, 3'd2, 32'h11110000));
        dirQ.push_back(makeXfer(1'b1, 32'h0000_0024, 3'd2, 32'h22220000));
        dirQ.push_back(makeXfer(1'b1, 32'h0000_0028, 3'd2, 32'h33330000));
        dirQ.push_back(makeXfer(1'b1, 32'h0000_0003, 3'd1, 32'hDEADBEEF));
        dirQ.push_back(makeXfer(1'b0, 32'h0000_0000, 3'd2, 32'h0));
        randLeft = 600;
        runTraffic();

        resetMidStall();

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
